// File: rtl/fp16_approximate_multiplier_if.sv
// Operand/result bundle for the FP16 multiplier.
// master drives operands, slave returns the registered product.
interface fp16_approximate_multiplier_if;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        out_valid;

    modport master (
        output in_valid, a, b,
        input  result, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output result, out_valid
    );
endinterface

// File: rtl/fp16_approximate_multiplier.sv
// FP16 multiplier, one-cycle latency, exact signs/exponents/specials.
// FP16_MUL_EXACT_EN selects the 11x11 RNE significand path.
module fp16_approximate_multiplier (
    input  logic                         clk,
    input  logic                         rst,
    fp16_approximate_multiplier_if.slave bus
);
    logic [4:0] ea, eb;
    logic [9:0] fa, fb;
    logic       sgn;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic       any_zero, any_inf, any_nan;

    assign ea  = bus.a[14:10];
    assign eb  = bus.b[14:10];
    assign fa  = bus.a[9:0];
    assign fb  = bus.b[9:0];
    assign sgn = bus.a[15] ^ bus.b[15];

    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
    assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);
    assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
    assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);

    assign any_zero = a_zero | b_zero;
    assign any_inf  = a_inf | b_inf;
    assign any_nan  = a_nan | b_nan;

    logic signed [6:0] e_pre;
    logic signed [6:0] e_n;
    logic        [9:0] frac_n;

    assign e_pre = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;

`ifdef FP16_MUL_EXACT_EN
    logic [10:0] sa, sb;
    logic [21:0] p;
    logic [9:0]  tf;
    logic [10:0] fr;
    logic        g, s, rnd;

    assign sa = {1'b1, fa};
    assign sb = {1'b1, fb};
    assign p  = sa * sb;

    always_comb begin
        tf = p[19:10];
        g  = p[9];
        s  = |p[8:0];
        if (p[21]) begin
            tf = p[20:11];
            g  = p[10];
            s  = |p[9:0];
        end
        // round to nearest, ties to even on the kept lsb
        rnd    = g & (s | tf[0]);
        fr     = {1'b0, tf} + {10'd0, rnd};
        frac_n = fr[9:0];
        e_n    = e_pre + {6'd0, p[21]} + {6'd0, fr[10]};
    end
`else
    logic [6:0]  sa, sb;
    logic [13:0] p;
    logic        unused_lsbs;

    assign sa = {1'b1, fa[9:4]};
    assign sb = {1'b1, fb[9:4]};
    assign p  = sa * sb;
    assign unused_lsbs = ^{fa[3:0], fb[3:0], p[1:0]};

    always_comb begin
        e_n    = e_pre;
        frac_n = p[11:2];
        if (p[13]) begin
            e_n    = e_pre + 7'sd1;
            frac_n = p[12:3];
        end
    end
`endif

    logic ovf, unf;
    logic sel_nan, sel_inf, sel_zero;
    logic [15:0] res_n;

    assign ovf = (e_n >= 7'sd31);
    assign unf = (e_n <= 7'sd0);

    // mutually exclusive selects encode the special-case priority
    assign sel_nan  = any_nan | (any_inf & any_zero);
    assign sel_inf  = !sel_nan & (any_inf | (!any_zero & ovf));
    assign sel_zero = !sel_nan & !sel_inf & (any_zero | unf);

    always_comb begin
        res_n = {sgn, e_n[4:0], frac_n};
        unique case (1'b1)
            sel_nan:  res_n = 16'h7E00;
            sel_inf:  res_n = {sgn, 5'h1F, 10'h000};
            sel_zero: res_n = {sgn, 15'h0000};
            default:  res_n = {sgn, e_n[4:0], frac_n};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result    <= 16'h0000;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result <= res_n;
            end
        end
    end
endmodule

// File: tb/tb_fp16_approximate_multiplier.sv
// Scoreboard bench for fp16_approximate_multiplier.
// Directed vectors, random positive operands, async reset checks.
module tb_fp16_approximate_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fp16_approximate_multiplier_if bus ();

    fp16_approximate_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        vq[$];
    logic [15:0] rq[$];
    logic [15:0] held = 16'h0000;

`ifdef FP16_MUL_EXACT_EN
    localparam logic [15:0] EXP_3C3F = 16'h3C3F;
`else
    localparam logic [15:0] EXP_3C3F = 16'h3C30;
`endif

    logic [47:0] vec [0:11];

    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        int     xe, ye, e;
        int     xf, yf;
        logic   sg;
        logic   xz, yz, xi, yi, xn, yn;
        longint p, q, rem, half;
        int     sh;
        xe = int'(x[14:10]);
        ye = int'(y[14:10]);
        xf = int'(x[9:0]);
        yf = int'(y[9:0]);
        sg = x[15] ^ y[15];
        xz = (xe == 0);
        yz = (ye == 0);
        xi = (xe == 31) && (xf == 0);
        yi = (ye == 31) && (yf == 0);
        xn = (xe == 31) && (xf != 0);
        yn = (ye == 31) && (yf != 0);
        if (xn || yn || ((xi || yi) && (xz || yz))) return 16'h7E00;
        if (xi || yi) return {sg, 15'h7C00};
        if (xz || yz) return {sg, 15'h0000};
        e = xe + ye - 15;
`ifdef FP16_MUL_EXACT_EN
        p  = longint'(1024 + xf) * longint'(1024 + yf);
        sh = (p >= 64'd2097152) ? 11 : 10;
        if (sh == 11) e = e + 1;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q >= 2048) begin
            q = q >> 1;
            e = e + 1;
        end
`else
        p = longint'((1024 + xf) / 16) * longint'((1024 + yf) / 16);
        if (p >= 8192) begin
            e = e + 1;
            q = p / 8;
        end else begin
            q = p / 4;
        end
`endif
        if (e >= 31) return {sg, 15'h7C00};
        if (e <= 0) return {sg, 15'h0000};
        return {sg, e[4:0], q[9:0]};
    endfunction

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp_r);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = x;
        bus.b        = y;
        vq.push_back(v);
        if (v) rq.push_back(exp_r);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        logic v;
        forever begin
            @(posedge clk);
            #1;
            if (vq.size() > 0) begin
                v = vq.pop_front();
                check("out_valid", {15'd0, bus.out_valid}, {15'd0, v});
                if (v && rq.size() > 0) held = rq.pop_front();
                check("result", bus.result, held);
            end
        end
    end

    initial begin : stim
        logic [15:0] x, y;
        logic        v;
        int          n;
        vec[0]  = {16'h3C00, 16'h3C00, 16'h3C00};
        vec[1]  = {16'h4000, 16'h4000, 16'h4400};
        vec[2]  = {16'hBC00, 16'h3C00, 16'hBC00};
        vec[3]  = {16'h3800, 16'h3400, 16'h3000};
        vec[4]  = {16'h3E00, 16'h4100, 16'h4380};
        vec[5]  = {16'h7800, 16'h7400, 16'h7C00};
        vec[6]  = {16'h7C00, 16'h0000, 16'h7E00};
        vec[7]  = {16'h7C00, 16'hBC00, 16'hFC00};
        vec[8]  = {16'h0400, 16'h0400, 16'h0000};
        vec[9]  = {16'h3C3F, 16'h3C00, EXP_3C3F};
        vec[10] = {16'h7E01, 16'h3C00, 16'h7E00};
        vec[11] = {16'h8000, 16'h3C00, 16'h8000};

        bus.in_valid = 1'b1;
        bus.a        = 16'h0000;
        bus.b        = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", bus.result, 16'h0000);
        check("reset_valid", {15'd0, bus.out_valid}, 16'h0000);

        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vec[i][47:32], vec[i][31:16], vec[i][15:0]);
        end
        drive(1'b0, 16'h1234, 16'h5678, 16'h0000);

        for (int i = 0; i < 1000; i++) begin
            v = 1'(($urandom_range(0, 2) != 0));
            x = 16'($urandom()) & 16'h7FFF;
            y = 16'($urandom()) & 16'h7FFF;
            drive(v, x, y, model(x, y));
        end
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        n = 0;
        while (vq.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (vq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d want 0 pending", vq.size());
        end

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 16'h4000;
        bus.b        = 16'h3E00;
        @(posedge clk);
        #1;
        check("pre_rst_result", bus.result, 16'h4200);
        check("pre_rst_valid", {15'd0, bus.out_valid}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_result", bus.result, 16'h0000);
        check("async_rst_valid", {15'd0, bus.out_valid}, 16'h0000);
        repeat (2) @(posedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp16_approximate_multiplier.md
# fp16_approximate_multiplier

Single-cycle-latency IEEE-754 binary16 multiplier with a reduced-precision significand datapath, used as the per-PE multiply stage of the TPU systolic array. Exponents, signs and special values are handled exactly. The significand product is computed from truncated operands and truncated again on output, which trades accuracy for area and power. The result is registered on one clock edge.

## Interface
Parameters:
- none (precision mode selected by macro, see Configuration)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  a/b valid this cycle
- a  input  16  FP16 operand A (sign[15], exp[14:10], frac[9:0])
- b  input  16  FP16 operand B
- result  output  16  registered FP16 product
- out_valid  output  1  result corresponds to operands presented one cycle earlier

## Operation
- Classify each operand:
  - exp=0 → zero. Subnormals are flushed to zero.
  - exp=31, frac=0 → Inf.
  - exp=31, frac≠0 → NaN.
  - otherwise → normal.
- Sign = a[15] XOR b[15]. The sign applies to zero and Inf results.
- Special cases, in priority order:
  1. Any NaN, or Inf×zero → 16'h7E00 (canonical qNaN, sign forced 0).
  2. Any Inf → {sign, 5'h1F, 10'h000}.
  3. Any zero → {sign, 15'h0000}.
- Normal path, approximate (default):
  - sa = {1, a[9:4]} and sb = {1, b[9:4]} (7 bits each). p = sa*sb (14 bits, value in [1,4)·2^12).
  - Biased exponent e = ea + eb − 15, computed in signed 7 bits.
  - If p[13]=1: e = e+1, frac = p[12:3]. Else frac = p[11:2].
  - No rounding (truncate).
- Overflow: e ≥ 31 → {sign, 5'h1F, 0} (signed Inf).
- Underflow: e ≤ 0 → {sign, 15'h0} (no subnormal outputs).
- All inputs are accepted every cycle. There is no back-pressure.

## Timing
- Reset values: result = 16'h0000, out_valid = 0. Reset is asynchronous; it clears both outputs immediately, including mid-stream.
- Latency 1 cycle. Operands sampled at edge N produce result/out_valid after edge N.
- out_valid follows in_valid, delayed by 1 cycle.
- result updates only when in_valid=1 and holds otherwise.
- Throughput one product per cycle. Back-to-back operands are fully independent.
- The combinational path from a/b to the result register must close at the array clock. No multicycle path is allowed.

## Configuration
- FP16_MUL_EXACT_EN:
  - Defined: full 11×11 significand product ({1,frac} for each operand, 22-bit result), rounded to nearest-even. A rounding carry may increment the exponent, and overflow is re-checked after rounding.
  - Undefined: the truncated 7×7 approximate path above.
- Special-case handling, interface and latency are identical in both modes.

## Test plan
- Reset then 0000×0000 with in_valid=1 → after reset: result=0000, out_valid=0. One cycle after the operand: result=0000, out_valid=1.
- 3C00×3C00 → 3C00 (1.0). 4000×4000 → 4400 (exp field 17). BC00×3C00 → BC00 (negative).
- 3800×3400 → 3000 (0.125). 3E00×4100 → 4380 (3.75). Results are exact in both modes.
- 7800×7400 → 7C00 (overflow to +Inf). 7C00×0000 → 7E00. 7C00×BC00 → FC00. 0400×0400 → 0000 (underflow flush).
- 3C3F×3C00 → 3C30 in approximate mode; 3C3F with FP16_MUL_EXACT_EN defined.
- Random positive operands (a, b masked with 16'h7FFF), 1000 back-to-back cycles with in_valid toggling → compare each result against a golden model of the selected mode. out_valid must match in_valid delayed by one cycle. Assert rst mid-stream → both outputs clear immediately.
